// File: rtl/fc_seq_ctrl.sv
// Sequencer for one fully-connected layer: loads an N-sample input vector, then walks the
// weight ROM one row group at a time, driving the P-lane MAC datapath and streaming lane results out.
module fc_seq_ctrl #(
   parameter int M = 8,
   parameter int N = 10,
   parameter int T = 16,
   parameter int P = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       input_valid,
   output logic                       input_ready,
   input  logic                       output_ready,
   output logic                       output_valid,
   output logic [$clog2(N)-1:0]       addr_x,
   output logic                       wr_en_x,
   output logic [$clog2(M*N/P)-1:0]   addr_w,
   output logic                       clear_acc,
   output logic                       en_acc,
   output logic [P-1:0]               f_sel,
   output logic [2:0]                 dbg_state
);

   localparam int XW = $clog2(N);
   localparam int AW = $clog2(M*N/P);
   localparam int G  = M / P;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int KW = (P > 1) ? $clog2(P) : 1;

   if (((M % P) != 0) || (T < 1)) begin : g_param_check
      $error("fc_seq_ctrl: M must be a multiple of P and T must be positive");
   end

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_CLEAR = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XW-1:0]   r_j;
   logic [XW-1:0]   w_j_nxt;
   logic [GW-1:0]   r_g;
   logic [GW-1:0]   w_g_nxt;
   logic [KW-1:0]   r_k;
   logic [KW-1:0]   w_k_nxt;
   logic            r_issue;
   logic [AW-1:0]   w_addr_w;
   logic            w_last_j;
   logic            w_last_g;
   logic            w_last_k;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and an offered output stays put until it is taken.
   assign w_last_j = (r_j == XW'(N - 1));
   assign w_last_g = (r_g == GW'(G - 1));
   assign w_last_k = (r_k == KW'(P - 1));
   assign w_addr_w = AW'(r_g) * AW'(N) + AW'(r_j);

   // ROM and input memory return data one cycle after the address, so en_acc trails issue by one.
   assign en_acc    = r_issue;
   assign f_sel     = P'(1) << r_k;
   assign dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_LOAD;
         r_j     <= '0;
         r_g     <= '0;
         r_k     <= '0;
         r_issue <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_j     <= w_j_nxt;
         r_g     <= w_g_nxt;
         r_k     <= w_k_nxt;
         r_issue <= (r_state == S_MAC);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_j_nxt      = r_j;
      w_g_nxt      = r_g;
      w_k_nxt      = r_k;
      input_ready  = 1'b0;
      wr_en_x      = 1'b0;
      clear_acc    = 1'b0;
      output_valid = 1'b0;
      addr_x       = '0;
      addr_w       = '0;
      case (r_state)
         S_LOAD: begin
            input_ready = 1'b1;
            addr_x      = r_j;
            wr_en_x     = input_valid;
            if (input_valid) begin
               if (w_last_j) begin
                  w_j_nxt     = '0;
                  w_g_nxt     = '0;
                  w_state_nxt = S_CLEAR;
               end else begin
                  w_j_nxt = r_j + 1'b1;
               end
            end
         end
         S_CLEAR: begin
            clear_acc   = 1'b1;
            w_state_nxt = S_MAC;
         end
         S_MAC: begin
            addr_x = r_j;
            addr_w = w_addr_w;
            if (w_last_j) begin
               w_j_nxt     = '0;
               w_state_nxt = S_DRAIN;
            end else begin
               w_j_nxt = r_j + 1'b1;
            end
         end
         S_DRAIN: begin
            w_k_nxt     = '0;
            w_state_nxt = S_OUT;
         end
         S_OUT: begin
            output_valid = 1'b1;
            if (output_ready) begin
               if (w_last_k) begin
                  w_k_nxt = '0;
                  if (w_last_g) begin
                     w_g_nxt     = '0;
                     w_state_nxt = S_LOAD;
                  end else begin
                     w_g_nxt     = r_g + 1'b1;
                     w_state_nxt = S_CLEAR;
                  end
               end else begin
                  w_k_nxt = r_k + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_LOAD;
         end
      endcase
   end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl: randomized load/stall traffic against a cycle schedule derived from the
// layer's rules (load N, clear 1, MAC N, drain 1, P outputs per group), for P=1 and P=2 instances.
module tb_fc_seq_ctrl;

   localparam int M = 8;
   localparam int N = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic input_valid = 1'b0;
   logic output_ready = 1'b0;

   always #5 clk = ~clk;

   logic       ir1, ov1, we1, ca1, ea1;
   logic [3:0] ax1;
   logic [6:0] aw1;
   logic [0:0] fs1;
   logic [2:0] st1;
   logic       ir2, ov2, we2, ca2, ea2;
   logic [3:0] ax2;
   logic [5:0] aw2;
   logic [1:0] fs2;
   logic [2:0] st2;

   fc_seq_ctrl #(.M(M), .N(N), .T(16), .P(1)) dut (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir1),
      .output_ready(output_ready), .output_valid(ov1), .addr_x(ax1), .wr_en_x(we1),
      .addr_w(aw1), .clear_acc(ca1), .en_acc(ea1), .f_sel(fs1), .dbg_state(st1)
   );

   fc_seq_ctrl #(.M(M), .N(N), .T(16), .P(2)) dut_p2 (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir2),
      .output_ready(output_ready), .output_valid(ov2), .addr_x(ax2), .wr_en_x(we2),
      .addr_w(aw2), .clear_acc(ca2), .en_acc(ea2), .f_sel(fs2), .dbg_state(st2)
   );

   // Selects which instance the scenario tasks observe.
   logic       sel = 1'b0;
   int         cur_p = 1;
   logic       m_ir, m_ov, m_we, m_ca, m_ea;
   logic [3:0] m_ax;
   logic [7:0] m_aw;
   logic [1:0] m_fs;
   logic [2:0] m_st;

   assign m_ir = sel ? ir2 : ir1;
   assign m_ov = sel ? ov2 : ov1;
   assign m_we = sel ? we2 : we1;
   assign m_ca = sel ? ca2 : ca1;
   assign m_ea = sel ? ea2 : ea1;
   assign m_ax = sel ? ax2 : ax1;
   assign m_aw = sel ? {2'b00, aw2} : {1'b0, aw1};
   assign m_fs = sel ? fs2 : {1'b0, fs1};
   assign m_st = sel ? st2 : st1;

   int         test_cnt = 0;
   int         fail_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic step(input logic iv, input logic orr);
      @(negedge clk);
      input_valid  = iv;
      output_ready = orr;
      #1;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One full vector: load N samples, then every row group through CLEAR/MAC/DRAIN/OUT.
   // abort_j >= 0 asserts reset during group 0's MAC at that column and returns.
   task automatic run_vector(input int vprob, input int rprob, input int min_stall, input int abort_j);
      int         acc;
      int         cyc;
      int         stall;
      int         ng;
      logic       iv;
      logic       orr;
      logic [7:0] exp_aw;
      logic [1:0] exp_fs;
      ng  = M / cur_p;
      acc = 0;
      cyc = 0;
      while (acc < N && cyc < 2000) begin
         iv = (int'($urandom_range(0, 99)) < vprob);
         step(iv, rbit());
         cyc++;
         test_cnt++;
         if (m_ir !== 1'b1 || m_we !== iv || m_ca !== 1'b0 || m_ov !== 1'b0 || m_ea !== 1'b0 ||
             m_ax !== 4'(acc)) begin
            fail_cnt++;
            $display("FAIL load: ir=%b we=%b clr=%b ov=%b en=%b addr_x=%0d, required ir=1 we=%b clr=0 ov=0 en=0 addr_x=%0d",
                     m_ir, m_we, m_ca, m_ov, m_ea, m_ax, iv, acc);
         end
         if (iv) acc++;
      end
      if (acc < N) begin
         test_cnt++;
         fail_cnt++;
         $display("FAIL load_timeout: accepts=%0d, required %0d", acc, N);
         return;
      end
      for (int g = 0; g < ng; g++) begin
         step(rbit(), rbit());
         test_cnt++;
         if (m_ca !== 1'b1 || m_ea !== 1'b0 || m_ir !== 1'b0 || m_ov !== 1'b0 || m_aw !== 8'd0) begin
            fail_cnt++;
            $display("FAIL clear g=%0d: clr=%b en=%b ir=%b ov=%b addr_w=%0d, required clr=1 en=0 ir=0 ov=0 addr_w=0",
                     g, m_ca, m_ea, m_ir, m_ov, m_aw);
         end
         for (int j = 0; j < N; j++) exp_q.push_back(8'(g * N + j));
         for (int j = 0; j < N; j++) begin
            step(rbit(), rbit());
            exp_aw = exp_q.pop_front();
            test_cnt++;
            if (m_aw !== exp_aw || m_ax !== 4'(j) || m_ea !== (j > 0) || m_ir !== 1'b0 ||
                m_we !== 1'b0 || m_ca !== 1'b0 || m_ov !== 1'b0) begin
               fail_cnt++;
               $display("FAIL mac g=%0d j=%0d: addr_w=%0d addr_x=%0d en=%b ir=%b we=%b clr=%b ov=%b, required addr_w=%0d addr_x=%0d en=%b others 0",
                        g, j, m_aw, m_ax, m_ea, m_ir, m_we, m_ca, m_ov, exp_aw, j, (j > 0));
            end
            if (g == 0 && j == abort_j) begin
               exp_q.delete();
               reset = 1'b1;
               return;
            end
         end
         step(rbit(), rbit());
         test_cnt++;
         if (m_ea !== 1'b1 || m_aw !== 8'd0 || m_ax !== 4'd0 || m_ov !== 1'b0 || m_ca !== 1'b0) begin
            fail_cnt++;
            $display("FAIL drain g=%0d: en=%b addr_w=%0d addr_x=%0d ov=%b clr=%b, required en=1 addr_w=0 addr_x=0 ov=0 clr=0",
                     g, m_ea, m_aw, m_ax, m_ov, m_ca);
         end
         for (int k = 0; k < cur_p; k++) begin
            exp_fs = 2'(1 << k);
            stall  = 0;
            do begin
               orr = (stall >= min_stall) && (int'($urandom_range(0, 99)) < rprob);
               step(rbit(), orr);
               test_cnt++;
               if (m_ov !== 1'b1 || m_fs !== exp_fs || m_aw !== 8'd0 || m_ea !== 1'b0 ||
                   m_ir !== 1'b0 || m_we !== 1'b0) begin
                  fail_cnt++;
                  $display("FAIL out g=%0d k=%0d: ov=%b f_sel=%b addr_w=%0d en=%b ir=%b we=%b, required ov=1 f_sel=%b addr_w=0 en=0 ir=0 we=0",
                           g, k, m_ov, m_fs, m_aw, m_ea, m_ir, m_we, exp_fs);
               end
               if (!orr) stall++;
            end while (!orr && stall <= 200);
            if (!orr) begin
               test_cnt++;
               fail_cnt++;
               $display("FAIL out_timeout g=%0d k=%0d: no handshake in %0d cycles, required one", g, k, stall);
               return;
            end
         end
      end
      step(1'b0, rbit());
      test_cnt++;
      if (m_ir !== 1'b1 || m_ax !== 4'd0 || m_ca !== 1'b0 || m_ov !== 1'b0 || m_ea !== 1'b0) begin
         fail_cnt++;
         $display("FAIL reload: ir=%b addr_x=%0d clr=%b ov=%b en=%b, required ir=1 addr_x=0 clr=0 ov=0 en=0",
                  m_ir, m_ax, m_ca, m_ov, m_ea);
      end
   endtask

   task automatic check_reset_values(input string name);
      test_cnt++;
      if (m_ir !== 1'b1 || m_ov !== 1'b0 || m_we !== 1'b0 || m_ca !== 1'b0 || m_ea !== 1'b0 ||
          m_ax !== 4'd0 || m_aw !== 8'd0 || m_fs !== 2'b01) begin
         fail_cnt++;
         $display("FAIL %s: ir=%b ov=%b we=%b clr=%b en=%b addr_x=%0d addr_w=%0d f_sel=%b st=%0d, required ir=1 ov=0 we=0 clr=0 en=0 addr_x=0 addr_w=0 f_sel=01",
                  name, m_ir, m_ov, m_we, m_ca, m_ea, m_ax, m_aw, m_fs, m_st);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step(rbit(), rbit());
      @(negedge clk);
      reset        = 1'b0;
      input_valid  = 1'b0;
      output_ready = rbit();
      #1;
      check_reset_values("reset");
   endtask

   task automatic test_full_stream();
      run_vector(100, 100, 0, -1);
   endtask

   task automatic test_back_to_back();
      run_vector(100, 100, 0, -1);
      run_vector(100, 100, 0, -1);
   endtask

   task automatic test_bubbles();
      run_vector(50, 100, 0, -1);
   endtask

   task automatic test_backpressure();
      run_vector(70, 60, 5, -1);
   endtask

   task automatic test_reset_mid();
      run_vector(100, 100, 0, 4);
      @(negedge clk);
      reset       = 1'b0;
      input_valid = 1'b0;
      #1;
      check_reset_values("reset_mid");
      run_vector(100, 100, 0, -1);
   endtask

   task automatic test_p2();
      run_vector(80, 70, 0, -1);
      run_vector(100, 100, 2, -1);
   endtask

   initial begin
      sel   = 1'b0;
      cur_p = 1;
      test_reset();
      test_full_stream();
      test_back_to_back();
      test_bubbles();
      test_backpressure();
      test_reset_mid();
      sel   = 1'b1;
      cur_p = 2;
      test_reset();
      test_p2();
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
